data_rd_seq: RTL
================

# data_rd_seq

Read sequencer that sits directly downstream of the SIMD row data buffer. On a start command it walks a contiguous, wrapping range of buffer rows through the buffer's combinational read port. It registers each row and streams it to the SIMD MAC array over a valid/ready handshake, marking the final row. It sustains one row per cycle under no back-pressure and stalls the buffer reads cleanly when the consumer stalls.

## Interface
Parameters:
- ADDR_BW, 6, buffer row address width
- ROW_CNT, 64, buffer depth in rows; need not be a power of two; ≤ 2^ADDR_BW
- MAC_BW, 8, bits per MAC lane
- COL_BW, 16, lanes per row; row width ROW_W = MAC_BW*COL_BW

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle command pulse; ignored while busy
- abort  in  1  synchronous cancel, any state
- base_addr  in  ADDR_BW  first row to read; sampled with start
- row_num  in  ADDR_BW+1  number of rows to stream; sampled with start
- busy  out  1  high when state ≠ IDLE
- done  out  1  one-cycle pulse after the final row handshake
- rd_en  out  1  buffer read strobe (combinational)
- rd_addr  out  ADDR_BW  buffer read address (combinational)
- rd_data  in  ROW_W  buffer read data, valid in the same cycle as rd_addr
- o_valid  out  1  output row valid
- o_ready  in  1  consumer accepts the row
- o_data  out  ROW_W  output row
- o_last  out  1  qualifies the final row of the command; meaningful only with o_valid

## Operation
- Reset values: state IDLE, busy 0, done 0, rd_en 0, rd_addr 0, o_valid 0, o_last 0, o_data 0, internal counters 0.
- FSM states:
  - IDLE
    - start with row_num==0: done pulses next cycle; no reads issued; remain IDLE.
    - start with row_num≠0: latch cur_addr=base_addr and remaining=row_num; go to RUN.
  - RUN
    - Issue condition: (!o_valid || o_ready).
    - When the issue condition holds: rd_en=1 and rd_addr=cur_addr; on the clock edge, o_data<=rd_data, o_valid<=1, o_last<=(remaining==1).
    - On each issue, cur_addr advances: cur_addr==ROW_CNT-1 → 0, else +1. remaining decrements.
    - When the issue condition fails: rd_en=0 and the output register holds.
    - Issue of the last row → DRAIN.
  - DRAIN
    - rd_en=0.
    - On the o_valid && o_ready handshake of the last row: o_valid<=0, done<=1, go to IDLE.
- Outside RUN issue cycles, rd_en=0 and rd_addr=0.
- Handshake
  - o_data, o_valid and o_last are stable while o_valid && !o_ready.
  - o_valid falls only after a handshake with nothing new issued.
- row_num > ROW_CNT is legal: the address wraps and rows are re-read in order.
- abort
  - Next state IDLE; o_valid, o_last and done cleared; no done pulse.
  - An abort coinciding with start wins.
  - An abort coinciding with the final handshake also suppresses done.
- start while busy is ignored; no queuing.
- Write/read collision: if the upstream writer targets cur_addr in the issue cycle, the pre-write row is streamed. The buffer's combinational read of its register array guarantees this.
- Asynchronous reset mid-command returns every output to its reset value immediately. No done pulse.

## Timing
- start in cycle t with o_ready held high, N = row_num:
  - busy: high from t+1.
  - rd_en: high t+1 … t+N.
  - o_valid: high t+2 … t+N+1.
  - o_last: high in t+N+1.
  - done: high in t+N+2, with busy low.
- Latency from start to first o_valid: 2 cycles.
- Steady-state throughput: 1 row per cycle.
- Each o_ready low cycle while o_valid is high delays all subsequent events by one cycle. rd_en is 0 in that cycle.
- A new start is accepted in the done cycle, since the FSM is already in IDLE.

## Structure
- Shared package holds:
  - ADDR_BW, ROW_CNT, MAC_BW and COL_BW defaults, plus derived ROW_W.
  - The state enum typedef (IDLE, RUN, DRAIN).
  - A typedef for a row word.
- The output register stage is a natural sub-module, row_out_reg: a ROW_W+1-bit valid/ready pipeline register with load enable and synchronous clear.
- The address/count datapath and the FSM stay in data_rd_seq.

## Test plan
- Basic stream: base_addr=0, row_num=4, o_ready=1, buffer preloaded row k = k*0x11 replicated → rows 0,1,2,3 on consecutive cycles t+2…t+5, o_last only on row 3, done at t+6.
- Wrap: ROW_CNT=64, base_addr=62, row_num=4 → rd_addr sequence 62,63,0,1; with ROW_CNT=48, base_addr=47, row_num=2 → 47,0.
- Back-pressure: row_num=3, o_ready toggles 1,0,0,1,1 → o_data held constant while stalled, rd_en=0 in stall cycles, no row lost or duplicated, done one cycle after last handshake.
- Zero/oversize: row_num=0 → done at t+1, rd_en never high; row_num=ROW_CNT+2 from base 0 → rows 0…ROW_CNT-1,0,1.
- Abort/start collisions: abort mid-RUN → o_valid low next cycle, no done; start during busy ignored; abort with final handshake → no done.
- Reset mid-command: assert rst_n low asynchronously during RUN → all outputs 0 immediately; after release, a fresh start behaves as in the basic stream scenario.

Source files
------------

// File: rtl/data_rd_seq_pkg.sv
// rtl/data_rd_seq_pkg.sv - shared parameters and types for the row read sequencer
package data_rd_seq_pkg;

  localparam int ADDR_BW = 6;
  localparam int ROW_CNT = 64;
  localparam int MAC_BW  = 8;
  localparam int COL_BW  = 16;
  localparam int ROW_W   = MAC_BW * COL_BW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  typedef logic [ROW_W-1:0] row_word_t;

endpackage

// File: rtl/data_rd_seq_row_out_reg.sv
// rtl/data_rd_seq_row_out_reg.sv - valid/ready output register for one row plus its last flag
module row_out_reg
  import data_rd_seq_pkg::*;
#(
  parameter int W = ROW_W + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // Clear beats load so a cancel never leaves a stray row behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/data_rd_seq.sv
// rtl/data_rd_seq.sv - walks a wrapping range of buffer rows and streams them over valid/ready
module data_rd_seq #(
  parameter int ADDR_BW = data_rd_seq_pkg::ADDR_BW,
  parameter int ROW_CNT = data_rd_seq_pkg::ROW_CNT,
  parameter int MAC_BW  = data_rd_seq_pkg::MAC_BW,
  parameter int COL_BW  = data_rd_seq_pkg::COL_BW
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [ADDR_BW-1:0]        base_addr,
  input  logic [ADDR_BW:0]          row_num,
  output logic                      busy,
  output logic                      done,
  output logic                      rd_en,
  output logic [ADDR_BW-1:0]        rd_addr,
  input  logic [MAC_BW*COL_BW-1:0]  rd_data,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic [MAC_BW*COL_BW-1:0]  o_data,
  output logic                      o_last
);

  import data_rd_seq_pkg::*;

  localparam int                 RW        = MAC_BW * COL_BW;
  localparam logic [ADDR_BW-1:0] LAST_ADDR = ADDR_BW'(ROW_CNT - 1);
  localparam logic [ADDR_BW:0]   ONE_ROW   = (ADDR_BW+1)'(1);

  seq_state_t         r_state;
  logic [ADDR_BW-1:0] r_cur_addr;
  logic [ADDR_BW:0]   r_remaining;
  logic               r_done;

  logic               w_issue;
  logic               w_is_last;
  logic               w_out_valid;
  logic [RW:0]        w_out_word;

  // A row may be fetched whenever the output slot is empty or being drained this cycle.
  assign w_issue   = (r_state == RUN) && (!w_out_valid || o_ready);
  assign w_is_last = (r_remaining == ONE_ROW);

  assign rd_en   = w_issue;
  assign rd_addr = w_issue ? r_cur_addr : '0;
  assign busy    = (r_state != IDLE);
  assign done    = r_done;
  assign o_valid = w_out_valid;
  assign o_data  = w_out_word[RW-1:0];
  assign o_last  = w_out_word[RW] & w_out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state     <= IDLE;
        r_cur_addr  <= '0;
        r_remaining <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              if (row_num == '0) begin
                r_done <= 1'b1;
              end else begin
                r_cur_addr  <= base_addr;
                r_remaining <= row_num;
                r_state     <= RUN;
              end
            end
          end
          RUN: begin
            if (w_issue) begin
              r_cur_addr  <= (r_cur_addr == LAST_ADDR) ? '0 : r_cur_addr + 1'b1;
              r_remaining <= r_remaining - ONE_ROW;
              if (w_is_last) begin
                r_state <= DRAIN;
              end
            end
          end
          DRAIN: begin
            if (w_out_valid && o_ready) begin
              r_done  <= 1'b1;
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  row_out_reg #(
    .W (RW + 1)
  ) u_row_out_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (abort),
    .i_load  (w_issue),
    .i_data  ({w_is_last, rd_data}),
    .i_ready (o_ready),
    .o_valid (w_out_valid),
    .o_data  (w_out_word)
  );

endmodule
